maxpool_1d: RTL and testbench

MAXPOOL_1D -- requirements
Module: maxpool_1d

---
 rtl/cnn_pkg.sv | 16 +
 rtl/maxpool_ctrl.sv | 65 ++++++
 rtl/maxpool_1d.sv | 55 +++++
 tb/tb_maxpool_1d.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Types shared by the CNN datapath stages: default sample width, output-register
// state, and a counter-width helper that never returns zero bits.
package cnn_pkg;

  localparam int T_DEFAULT = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxpool_ctrl.sv
// Window/frame counters and EMPTY/FULL output state for maxpool_1d; x_ready is
// combinational (!y_valid || y_ready), forced low during reset, so a stalled output stalls the input.
module maxpool_ctrl
  import cnn_pkg::*;
#(
  parameter int L = 13,
  parameter int P = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic x_valid,
  input  logic y_ready,
  output logic x_ready,
  output logic in_xfer,
  output logic win_first,
  output logic win_close,
  output logic y_valid
);

  localparam int WW = min1_clog2(P);
  localparam int FW = min1_clog2(L);
  localparam logic [WW-1:0] WIN_LAST   = WW'(P - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(L - 1);

  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  out_state_e    state_q, state_d;

  assign y_valid   = (state_q == FULL);
  assign x_ready   = !reset && (!y_valid || y_ready);
  assign in_xfer   = x_valid && x_ready;
  assign win_first = (win_cnt_q == '0);
  // The last sample of a frame closes a window even if it is only partly filled.
  assign win_close = in_xfer && ((win_cnt_q == WIN_LAST) || (frame_cnt_q == FRAME_LAST));

  always_comb begin
    win_cnt_d   = win_cnt_q;
    frame_cnt_d = frame_cnt_q;
    state_d     = state_q;

    if (in_xfer) begin
      win_cnt_d   = win_close ? '0 : win_cnt_q + 1'b1;
      frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
    end

    case (state_q)
      EMPTY:   if (win_close) state_d = FULL;
      FULL:    if (y_ready && !win_close) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q   <= '0;
      frame_cnt_q <= '0;
      state_q     <= EMPTY;
    end else begin
      win_cnt_q   <= win_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: rtl/maxpool_1d.sv
// 1-D max pooling, window/stride P over L-sample frames; result registered 1 cycle after
// the closing sample. Backpressure: x_ready drops while a result waits on y_ready.
module maxpool_1d
  import cnn_pkg::*;
#(
  parameter int L = 13,
  parameter int P = 2,
  parameter int T = T_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);

  logic in_xfer, win_first, win_close;
  logic signed [T-1:0] max_q, max_d;
  logic signed [T-1:0] y_data_q, y_data_d;
  logic signed [T-1:0] combined;

  maxpool_ctrl #(.L(L), .P(P)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .x_valid   (x_valid),
    .y_ready   (y_ready),
    .x_ready   (x_ready),
    .in_xfer   (in_xfer),
    .win_first (win_first),
    .win_close (win_close),
    .y_valid   (y_valid)
  );

  always_comb begin
    combined = (win_first || (x_data > max_q)) ? x_data : max_q;
    max_d    = in_xfer ? combined : max_q;
    y_data_d = win_close ? combined : y_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q    <= '0;
      y_data_q <= '0;
    end else begin
      max_q    <= max_d;
      y_data_q <= y_data_d;
    end
  end

  assign y_data = y_data_q;

endmodule

// File: tb/tb_maxpool_1d.sv
// Bench for maxpool_1d: default instance checked against a frame/window reference model,
// plus two small-parameter instances (L=4,P=4 and L=4,P=1).
module tb_maxpool_1d;

  localparam int L_D = 13;
  localparam int P_D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic signed [15:0] x_data, y_data;
  logic x_valid, x_ready, y_valid, y_ready;
  logic signed [15:0] a_x_data, a_y_data;
  logic a_x_valid, a_x_ready, a_y_valid, a_y_ready;
  logic signed [15:0] b_x_data, b_y_data;
  logic b_x_valid, b_x_ready, b_y_valid, b_y_ready;

  maxpool_1d #(.L(L_D), .P(P_D), .T(16)) dut (
    .clk(clk), .reset(reset), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  maxpool_1d #(.L(4), .P(4), .T(16)) dut_a (
    .clk(clk), .reset(reset), .x_data(a_x_data), .x_valid(a_x_valid), .x_ready(a_x_ready),
    .y_data(a_y_data), .y_valid(a_y_valid), .y_ready(a_y_ready)
  );

  maxpool_1d #(.L(4), .P(1), .T(16)) dut_b (
    .clk(clk), .reset(reset), .x_data(b_x_data), .x_valid(b_x_valid), .x_ready(b_x_ready),
    .y_data(b_y_data), .y_valid(b_y_valid), .y_ready(b_y_ready)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: samples of the current frame by position; a window's max is
  // pushed to exp_q once its last sample (by position) has been accepted.
  int exp_q[$];
  int fbuf[L_D];
  int mpos;
  int outs[$];

  bit o_xr, o_yv;
  int o_yd;

  task automatic model_reset();
    exp_q.delete();
    mpos = 0;
  endtask

  task automatic model_push(input int v, output bit closed);
    int start, m;
    fbuf[mpos] = v;
    closed = ((mpos % P_D) == P_D - 1) || (mpos == L_D - 1);
    if (closed) begin
      start = mpos - (mpos % P_D);
      m = fbuf[start];
      for (int k = start + 1; k <= mpos; k++) if (fbuf[k] > m) m = fbuf[k];
      exp_q.push_back(m);
    end
    mpos = (mpos == L_D - 1) ? 0 : mpos + 1;
  endtask

  // Drive one cycle on the default instance and sample its outputs mid-cycle.
  task automatic step(input bit xv, input int xd, input bit yr);
    x_valid = xv;
    x_data  = 16'(xd);
    y_ready = yr;
    @(negedge clk);
    o_xr = x_ready;
    o_yv = y_valid;
    o_yd = int'(y_data);
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_s16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    x_valid = 1'b1; x_data = 16'sd77; y_ready = 1'b1;
    a_x_valid = 1'b1; a_x_data = 16'sd5; a_y_ready = 1'b1;
    b_x_valid = 1'b1; b_x_data = 16'sd6; b_y_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL reset_x_ready: got %b, required 0", x_ready); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b, required 0", y_valid); end
    checks++; if (y_data !== 16'sd0) begin errors++; $display("FAIL reset_y_data: got %0d, required 0", y_data); end
    checks++; if (a_y_valid !== 1'b0 || b_y_valid !== 1'b0) begin
      errors++; $display("FAIL reset_param_y_valid: got %b/%b, required 0/0", a_y_valid, b_y_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    x_valid = 1'b0; a_x_valid = 1'b0; b_x_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    int vals[13] = '{5, 9, 2, 2, 0, 7, 3, 3, 8, 1, 4, 6, 11};
    int reqd[7]  = '{9, 2, 7, 3, 8, 6, 11};
    bit pend = 1'b0;
    bit xv;
    int xd;
    outs.delete();
    for (int i = 0; i < 16; i++) begin
      xv = (i < 13);
      xd = xv ? vals[i] : 0;
      step(xv, xd, 1'b1);
      checks++; if (o_xr !== 1'b1) begin errors++; $display("FAIL stream_x_ready[%0d]: got %b, required 1", i, o_xr); end
      checks++; if (o_yv !== pend) begin errors++; $display("FAIL stream_latency[%0d]: y_valid=%b, required %b", i, o_yv, pend); end
      if (o_yv) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stream_out: unexpected %0d, none required", o_yd); end
        else begin
          if (o_yd !== exp_q[0]) begin errors++; $display("FAIL stream_out: got %0d, required %0d", o_yd, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        outs.push_back(o_yd);
      end
      pend = 1'b0;
      if (xv && o_xr) model_push(xd, pend);
    end
    checks++; if (outs.size() != 7) begin errors++; $display("FAIL stream_count: got %0d, required 7", outs.size()); end
    for (int k = 0; k < 7 && k < outs.size(); k++) begin
      checks++; if (outs[k] != reqd[k]) begin errors++; $display("FAIL stream_value[%0d]: got %0d, required %0d", k, outs[k], reqd[k]); end
    end
  endtask

  task automatic test_negatives();
    int vals[13];
    bit cl;
    vals[0] = -5; vals[1] = -3; vals[2] = -7; vals[3] = -7;
    for (int i = 4; i < 13; i++) vals[i] = rand_s16();
    outs.delete();
    for (int i = 0; i < 15; i++) begin
      step(i < 13, (i < 13) ? vals[i] : 0, 1'b1);
      if (o_yv) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL neg_out: unexpected %0d, none required", o_yd); end
        else begin
          if (o_yd !== exp_q[0]) begin errors++; $display("FAIL neg_out: got %0d, required %0d", o_yd, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        outs.push_back(o_yd);
      end
      if (i < 13 && o_xr) model_push(vals[i], cl);
    end
    checks++;
    if (outs.size() < 2) begin errors++; $display("FAIL neg_count: got %0d outputs, required at least 2", outs.size()); end
    else if (outs[0] != -3 || outs[1] != -7) begin
      errors++; $display("FAIL neg_values: got %0d,%0d, required -3,-7", outs[0], outs[1]);
    end
  endtask

  task automatic test_backpressure();
    bit cl, yr;
    int xd, sent, cyc;
    step(1'b1, 10, 1'b1); model_push(10, cl);
    step(1'b1, 20, 1'b1); model_push(20, cl);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rand_s16(), 1'b0);
      checks++; if (o_xr !== 1'b0) begin errors++; $display("FAIL bp_x_ready[%0d]: got %b, required 0", i, o_xr); end
      checks++; if (o_yv !== 1'b1) begin errors++; $display("FAIL bp_y_valid[%0d]: got %b, required 1", i, o_yv); end
      checks++; if (o_yd !== 20) begin errors++; $display("FAIL bp_y_data[%0d]: got %0d, required 20", i, o_yd); end
    end
    step(1'b1, 33, 1'b1);
    checks++; if (o_yv !== 1'b1 || o_yd !== 20) begin
      errors++; $display("FAIL bp_release: got valid=%b data=%0d, required valid=1 data=20", o_yv, o_yd);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (o_xr) model_push(33, cl);
    step(1'b1, 44, 1'b1);
    checks++; if (o_yv !== 1'b0) begin errors++; $display("FAIL bp_duplicate: got y_valid=%b, required 0", o_yv); end
    if (o_xr) model_push(44, cl);
    sent = 0; cyc = 0;
    while (cyc < 200 && (sent < 9 || exp_q.size() > 0)) begin
      yr = (sent < 9) ? ($urandom_range(0, 1) == 1) : 1'b1;
      xd = rand_s16();
      step(sent < 9, xd, yr);
      if (o_yv && yr) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_out: unexpected %0d, none required", o_yd); end
        else begin
          if (o_yd !== exp_q[0]) begin errors++; $display("FAIL bp_out: got %0d, required %0d", o_yd, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (sent < 9 && o_xr) begin model_push(xd, cl); sent++; end
      cyc++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_loss: %0d outputs missing, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int vals[26];
    bit cl;
    for (int i = 0; i < 26; i++) vals[i] = int'($urandom_range(0, 1000));
    vals[12] = 30000;
    vals[13] = int'($urandom_range(0, 100));
    vals[14] = int'($urandom_range(0, 100));
    outs.delete();
    for (int i = 0; i < 28; i++) begin
      step(i < 26, (i < 26) ? vals[i] : 0, 1'b1);
      checks++; if (o_xr !== 1'b1) begin errors++; $display("FAIL b2b_x_ready[%0d]: got %b, required 1", i, o_xr); end
      if (o_yv) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_out: unexpected %0d, none required", o_yd); end
        else begin
          if (o_yd !== exp_q[0]) begin errors++; $display("FAIL b2b_out: got %0d, required %0d", o_yd, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        outs.push_back(o_yd);
      end
      if (i < 26 && o_xr) model_push(vals[i], cl);
    end
    checks++; if (outs.size() != 14) begin errors++; $display("FAIL b2b_count: got %0d, required 14", outs.size()); end
  endtask

  task automatic test_reset_midframe();
    int vals[13] = '{5, 9, 2, 2, 0, 7, 3, 3, 8, 1, 4, 6, 11};
    int reqd[7]  = '{9, 2, 7, 3, 8, 6, 11};
    int xd;
    bit cl;
    for (int i = 0; i < 4; i++) begin
      xd = int'($urandom_range(0, 500));
      step(1'b1, xd, 1'b1);
      if (o_yv && exp_q.size() > 0) void'(exp_q.pop_front());
      if (o_xr) model_push(xd, cl);
    end
    reset = 1'b1;
    step(1'b0, 0, 1'b0);
    checks++; if (o_xr !== 1'b0) begin errors++; $display("FAIL midrst_x_ready: got %b, required 0", o_xr); end
    reset = 1'b0;
    model_reset();
    outs.delete();
    for (int i = 0; i < 16; i++) begin
      step(i < 13, (i < 13) ? vals[i] : 0, 1'b1);
      if (i == 0) begin
        checks++; if (o_yv !== 1'b0) begin errors++; $display("FAIL midrst_stale_valid: got %b, required 0", o_yv); end
      end
      if (o_yv) outs.push_back(o_yd);
    end
    checks++; if (outs.size() != 7) begin errors++; $display("FAIL midrst_count: got %0d, required 7", outs.size()); end
    for (int k = 0; k < 7 && k < outs.size(); k++) begin
      checks++; if (outs[k] != reqd[k]) begin errors++; $display("FAIL midrst_value[%0d]: got %0d, required %0d", k, outs[k], reqd[k]); end
    end
  endtask

  task automatic test_random();
    bit xv, yr, cl;
    int xd;
    for (int i = 0; i < 320; i++) begin
      xv = (i < 300) && ($urandom_range(0, 3) != 0);
      yr = (i >= 300) || ($urandom_range(0, 2) != 0);
      xd = rand_s16();
      step(xv, xd, yr);
      checks++; if (o_xr !== (!o_yv || yr)) begin
        errors++; $display("FAIL rand_x_ready[%0d]: got %b, required %b", i, o_xr, (!o_yv || yr));
      end
      if (o_yv && yr) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_out: unexpected %0d, none required", o_yd); end
        else begin
          if (o_yd !== exp_q[0]) begin errors++; $display("FAIL rand_out: got %0d, required %0d", o_yd, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (xv && o_xr) model_push(xd, cl);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_loss: %0d outputs missing, required 0", exp_q.size()); end
  endtask

  task automatic test_params();
    int r[8];
    for (int i = 0; i < 6; i++) begin
      a_x_valid = (i < 4); a_x_data = 16'(i + 1); a_y_ready = 1'b1;
      @(negedge clk);
      checks++; if (a_x_ready !== 1'b1) begin errors++; $display("FAIL p4_x_ready[%0d]: got %b, required 1", i, a_x_ready); end
      checks++; if (a_y_valid !== (i == 4)) begin errors++; $display("FAIL p4_y_valid[%0d]: got %b, required %b", i, a_y_valid, (i == 4)); end
      if (i == 4) begin
        checks++; if (a_y_data !== 16'sd4) begin errors++; $display("FAIL p4_y_data: got %0d, required 4", a_y_data); end
      end
      @(posedge clk); #1;
    end
    a_x_valid = 1'b0;
    for (int i = 0; i < 8; i++) r[i] = rand_s16();
    for (int i = 0; i < 9; i++) begin
      b_x_valid = (i < 8); b_x_data = (i < 8) ? 16'(r[i]) : 16'sd0; b_y_ready = 1'b1;
      @(negedge clk);
      checks++; if (b_y_valid !== (i > 0)) begin errors++; $display("FAIL p1_y_valid[%0d]: got %b, required %b", i, b_y_valid, (i > 0)); end
      if (i > 0) begin
        checks++; if (int'(b_y_data) != r[i-1]) begin errors++; $display("FAIL p1_y_data[%0d]: got %0d, required %0d", i, b_y_data, r[i-1]); end
      end
      @(posedge clk); #1;
    end
    b_x_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_negatives();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
